// File: rtl/decode_regfile_pipe_if.sv
// rtl/decode_regfile_pipe_if.sv - fetch/writeback/execute signal bundle for the decode stage
interface decode_regfile_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic            out_bad_reg;

  modport master (
    output in_valid, in_inst, in_pc, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data,
           out_imm, out_rd, out_bad_reg
  );

  modport slave (
    input  in_valid, in_inst, in_pc, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data,
           out_imm, out_rd, out_bad_reg
  );
endinterface

// File: rtl/decode_regfile_pipe.sv
// rtl/decode_regfile_pipe.sv - RV32I decode stage: register file, immediate generator, registered handshake slot
module decode_regfile_pipe #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int BYPASS    = 1
) (
  input logic clk,
  input logic rst,
  decode_regfile_pipe_if.slave bus
);
  localparam int IW = $clog2(REG_COUNT);

  logic [XLEN-1:0] regs [REG_COUNT];

  logic            slot_valid;
  logic [XLEN-1:0] slot_pc;
  logic [31:0]     slot_inst;
  logic [XLEN-1:0] slot_rs1;
  logic [XLEN-1:0] slot_rs2;
  logic [XLEN-1:0] slot_imm;
  logic [4:0]      slot_rd;
  logic            slot_bad;

  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [4:0]      rd_idx;
  logic            wb_ok;
  logic            in_ready;
  logic            accept;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;
  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;
  logic            refresh_rs1;
  logic            refresh_rs2;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            bad_reg;

  function automatic logic in_range(input logic [4:0] idx);
    return int'(idx) < REG_COUNT;
  endfunction

  assign rs1_idx  = bus.in_inst[19:15];
  assign rs2_idx  = bus.in_inst[24:20];
  assign rd_idx   = bus.in_inst[11:7];
  assign wb_ok    = bus.wb_en && (bus.wb_rd != 5'd0) && in_range(bus.wb_rd);
  assign in_ready = !slot_valid || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign rf_rs1 = ((rs1_idx != 5'd0) && in_range(rs1_idx)) ? regs[rs1_idx[IW-1:0]] : '0;
  assign rf_rs2 = ((rs2_idx != 5'd0) && in_range(rs2_idx)) ? regs[rs2_idx[IW-1:0]] : '0;

  assign cap_rs1 = ((BYPASS != 0) && wb_ok && (bus.wb_rd == rs1_idx)) ? bus.wb_data : rf_rs1;
  assign cap_rs2 = ((BYPASS != 0) && wb_ok && (bus.wb_rd == rs2_idx)) ? bus.wb_data : rf_rs2;

  // A held instruction keeps tracking writebacks so it never leaves with stale operands.
  assign refresh_rs1 = slot_valid && wb_ok && (bus.wb_rd == slot_inst[19:15]);
  assign refresh_rs2 = slot_valid && wb_ok && (bus.wb_rd == slot_inst[24:20]);

  assign bad_reg = !in_range(rs1_idx) || !in_range(rs2_idx) || !in_range(rd_idx);

  always_comb begin
    imm32 = '0;
    case (bus.in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        imm32 = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
      7'b0100011:
        imm32 = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
      7'b1100011:
        imm32 = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                 bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {bus.in_inst[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                 bus.in_inst[20], bus.in_inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_ok) begin
      regs[bus.wb_rd[IW-1:0]] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= 1'b0;
      slot_pc    <= '0;
      slot_inst  <= '0;
      slot_rs1   <= '0;
      slot_rs2   <= '0;
      slot_imm   <= '0;
      slot_rd    <= '0;
      slot_bad   <= 1'b0;
    end else if (accept) begin
      slot_valid <= 1'b1;
      slot_pc    <= bus.in_pc;
      slot_inst  <= bus.in_inst;
      slot_rs1   <= cap_rs1;
      slot_rs2   <= cap_rs2;
      slot_imm   <= imm_ext;
      slot_rd    <= rd_idx;
      slot_bad   <= bad_reg;
    end else begin
      if (bus.out_ready) begin
        slot_valid <= 1'b0;
      end
      if (refresh_rs1) begin
        slot_rs1 <= bus.wb_data;
      end
      if (refresh_rs2) begin
        slot_rs2 <= bus.wb_data;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = slot_valid;
  assign bus.out_pc       = slot_pc;
  assign bus.out_inst     = slot_inst;
  assign bus.out_rs1_data = slot_rs1;
  assign bus.out_rs2_data = slot_rs2;
  assign bus.out_imm      = slot_imm;
  assign bus.out_rd       = slot_rd;
  assign bus.out_bad_reg  = slot_bad;
endmodule

// File: tb/tb_decode_regfile_pipe.sv
// tb/tb_decode_regfile_pipe.sv - self-checking bench for decode_regfile_pipe (RV32I, no-bypass and RV32E/64-bit variants)
module tb_decode_regfile_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_regfile_pipe_if #(.XLEN(32)) bus ();
  decode_regfile_pipe_if #(.XLEN(32)) bus_nb ();
  decode_regfile_pipe_if #(.XLEN(64)) bus_e ();

  decode_regfile_pipe #(.XLEN(32), .REG_COUNT(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  decode_regfile_pipe #(.XLEN(32), .REG_COUNT(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .bus(bus_nb)
  );
  decode_regfile_pipe #(.XLEN(64), .REG_COUNT(16), .BYPASS(1)) dut_e (
    .clk(clk), .rst(rst), .bus(bus_e)
  );

  // All three variants see the same stimulus.
  assign bus_nb.in_valid  = bus.in_valid;
  assign bus_nb.in_inst   = bus.in_inst;
  assign bus_nb.in_pc     = bus.in_pc;
  assign bus_nb.wb_en     = bus.wb_en;
  assign bus_nb.wb_rd     = bus.wb_rd;
  assign bus_nb.wb_data   = bus.wb_data;
  assign bus_nb.out_ready = bus.out_ready;
  assign bus_e.in_valid   = bus.in_valid;
  assign bus_e.in_inst    = bus.in_inst;
  assign bus_e.in_pc      = {32'h0, bus.in_pc};
  assign bus_e.wb_en      = bus.wb_en;
  assign bus_e.wb_rd      = bus.wb_rd;
  assign bus_e.wb_data    = {32'h0, bus.wb_data};
  assign bus_e.out_ready  = bus.out_ready;

  typedef struct {
    logic [31:0] inst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        bad;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        bad;
  } exp_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];
  exp_t sb_q [$];
  bit   sb_on = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
  endtask

  always @(negedge clk) begin
    if (sb_on && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_output: got inst 0x%0h with no expected entry", bus.out_inst);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_pc",   64'(bus.out_pc),       64'(e.pc));
        chk("sb_inst", 64'(bus.out_inst),     64'(e.inst));
        chk("sb_rs1",  64'(bus.out_rs1_data), 64'(e.rs1));
        chk("sb_rs2",  64'(bus.out_rs2_data), 64'(e.rs2));
        chk("sb_imm",  64'(bus.out_imm),      64'(e.imm));
        chk("sb_rd",   64'(bus.out_rd),       64'(e.rd));
        chk("sb_bad",  64'(bus.out_bad_reg),  64'(e.bad));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h000280B3, 1'b0, 5'd0,  32'h0,    32'hDEADBEEF, 32'h0,    32'h0,        5'd1,  1'b0};
    vecs[1]  = '{32'hFE010CE3, 1'b0, 5'd0,  32'h0,    32'h0,        32'h0,    32'hFFFFFFF8, 5'd25, 1'b0};
    vecs[2]  = '{32'h800000EF, 1'b0, 5'd0,  32'h0,    32'h0,        32'h0,    32'hFFF00000, 5'd1,  1'b0};
    vecs[3]  = '{32'hFFFFF0B7, 1'b0, 5'd0,  32'h0,    32'h0,        32'h0,    32'hFFFFF000, 5'd1,  1'b0};
    vecs[4]  = '{32'h006281FF, 1'b0, 5'd0,  32'h0,    32'hDEADBEEF, 32'h10,   32'h0,        5'd3,  1'b0};
    vecs[5]  = '{32'hFE62AE23, 1'b0, 5'd0,  32'h0,    32'hDEADBEEF, 32'h10,   32'hFFFFFFFC, 5'd28, 1'b0};
    vecs[6]  = '{32'h12345017, 1'b0, 5'd0,  32'h0,    32'h0,        32'h0,    32'h12345000, 5'd0,  1'b0};
    vecs[7]  = '{32'hFFF38413, 1'b1, 5'd7,  32'h1234, 32'h1234,     32'h0,    32'hFFFFFFFF, 5'd8,  1'b0};
    vecs[8]  = '{32'h007A04B3, 1'b0, 5'd0,  32'h0,    32'hAAAA,     32'h1234, 32'h0,        5'd9,  1'b0};
    vecs[9]  = '{32'h000280B3, 1'b1, 5'd5,  32'h5A5A, 32'h5A5A,     32'h0,    32'h0,        5'd1,  1'b0};
    vecs[10] = '{32'h000000B3, 1'b1, 5'd0,  32'hFFFF, 32'h0,        32'h0,    32'h0,        5'd1,  1'b0};

    rst = 1'b1;
    drive_in(1'b0, 32'h0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    sample();
    chk("rst_out_valid", 64'(bus.out_valid),    64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),     64'd1);
    chk("rst_out_inst",  64'(bus.out_inst),     64'd0);
    chk("rst_out_rs1",   64'(bus.out_rs1_data), 64'd0);
    chk("rst_e_valid",   64'(bus_e.out_valid),  64'd0);

    // Preload: x0 and (for RV32E) x20 writes must be dropped.
    cyc();
    drive_wb(1'b1, 5'd5,  32'hDEADBEEF); cyc();
    drive_wb(1'b1, 5'd6,  32'h10);       cyc();
    drive_wb(1'b1, 5'd7,  32'h1111);     cyc();
    drive_wb(1'b1, 5'd20, 32'hAAAA);     cyc();
    drive_wb(1'b1, 5'd0,  32'hBBBB);     cyc();
    drive_wb(1'b0, 5'd0,  32'h0);

    // Back-to-back accepts with out_ready=1 exercise simultaneous consume/accept.
    sb_on = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      exp_t e;
      drive_in(1'b1, vecs[i].inst, 32'h1000 + 32'(i) * 4);
      drive_wb(vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data);
      e.pc   = 32'h1000 + 32'(i) * 4;
      e.inst = vecs[i].inst;
      e.rs1  = vecs[i].rs1;
      e.rs2  = vecs[i].rs2;
      e.imm  = vecs[i].imm;
      e.rd   = vecs[i].rd;
      e.bad  = vecs[i].bad;
      sb_q.push_back(e);
      cyc();
    end
    drive_in(1'b0, 32'h0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    cyc();
    sample();
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("sb_queue_empty",  64'(sb_q.size()),   64'd0);
    sb_on = 1'b0;

    // Same-cycle writeback: forwarded with BYPASS=1, old value with BYPASS=0.
    cyc();
    drive_wb(1'b1, 5'd7, 32'h2222); cyc();
    drive_in(1'b1, 32'hFFF38413, 32'h2000);
    drive_wb(1'b1, 5'd7, 32'h3333);
    cyc();
    drive_in(1'b0, 32'h0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    sample();
    chk("bypass_rs1",    64'(bus.out_rs1_data),    64'h3333);
    chk("nobypass_rs1",  64'(bus_nb.out_rs1_data), 64'h2222);

    // Stall with operand refresh.
    cyc();
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h00018533, 32'h3000);
    cyc();
    drive_in(1'b1, 32'h000280B3, 32'h3004);
    drive_wb(1'b1, 5'd3, 32'h55);
    sample();
    chk("stall_in_ready",  64'(bus.in_ready),     64'd0);
    chk("stall_out_valid", 64'(bus.out_valid),    64'd1);
    chk("stall_rs1_old",   64'(bus.out_rs1_data), 64'd0);
    cyc();
    drive_wb(1'b0, 5'd0, 32'h0);
    sample();
    chk("refresh_rs1",    64'(bus.out_rs1_data),    64'h55);
    chk("refresh_nb_rs1", 64'(bus_nb.out_rs1_data), 64'h55);
    chk("stall_inst",     64'(bus.out_inst),        64'h00018533);
    cyc();
    sample();
    chk("stall_hold_inst", 64'(bus.out_inst), 64'h00018533);
    chk("stall_hold_pc",   64'(bus.out_pc),   64'h3000);
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    drive_in(1'b0, 32'h0, 32'h0);
    sample();
    chk("release_inst",  64'(bus.out_inst),     64'h000280B3);
    chk("release_valid", 64'(bus.out_valid),    64'd1);
    chk("release_rs1",   64'(bus.out_rs1_data), 64'h5A5A);
    cyc();
    sample();
    chk("release_drain", 64'(bus.out_valid), 64'd0);

    // RV32E / XLEN=64 variant.
    cyc();
    drive_in(1'b1, 32'h011000B3, 32'h4000); cyc();
    drive_in(1'b0, 32'h0, 32'h0);
    sample();
    chk("e_bad_rs2",    64'(bus_e.out_bad_reg),  64'd1);
    chk("e_rs2_zero",   bus_e.out_rs2_data,      64'd0);
    chk("main_bad_rs2", 64'(bus.out_bad_reg),    64'd0);
    cyc();
    drive_in(1'b1, 32'hFFFFF0B7, 32'h4004); cyc();
    drive_in(1'b0, 32'h0, 32'h0);
    sample();
    chk("e_lui_imm64",  bus_e.out_imm,           64'hFFFFFFFFFFFFF000);
    chk("e_lui_bad",    64'(bus_e.out_bad_reg),  64'd1);
    cyc();
    drive_in(1'b1, 32'h000280B3, 32'h4008); cyc();
    drive_in(1'b0, 32'h0, 32'h0);
    sample();
    chk("e_rs1_x5",     bus_e.out_rs1_data,      64'h5A5A);
    chk("e_good_bad",   64'(bus_e.out_bad_reg),  64'd0);
    chk("e_pc",         bus_e.out_pc,            64'h4008);
    cyc();
    drive_in(1'b1, 32'h007A04B3, 32'h400C); cyc();
    drive_in(1'b0, 32'h0, 32'h0);
    sample();
    chk("e_x20_zero",   bus_e.out_rs1_data,      64'd0);
    chk("e_x20_bad",    64'(bus_e.out_bad_reg),  64'd1);
    chk("main_x20",     64'(bus.out_rs1_data),   64'hAAAA);

    // Reset overrides a held slot and a concurrent writeback/accept.
    cyc();
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h000280B3, 32'h5000); cyc();
    sample();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    cyc();
    rst = 1'b1;
    drive_in(1'b1, 32'h006281FF, 32'h5004);
    drive_wb(1'b1, 5'd5, 32'h99);
    cyc();
    rst = 1'b0;
    drive_in(1'b0, 32'h0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    sample();
    chk("rst2_valid",    64'(bus.out_valid),    64'd0);
    chk("rst2_pc",       64'(bus.out_pc),       64'd0);
    chk("rst2_inst",     64'(bus.out_inst),     64'd0);
    chk("rst2_rs1",      64'(bus.out_rs1_data), 64'd0);
    chk("rst2_rs2",      64'(bus.out_rs2_data), 64'd0);
    chk("rst2_imm",      64'(bus.out_imm),      64'd0);
    chk("rst2_rd",       64'(bus.out_rd),       64'd0);
    chk("rst2_bad",      64'(bus.out_bad_reg),  64'd0);
    chk("rst2_in_ready", 64'(bus.in_ready),     64'd1);
    cyc();
    bus.out_ready = 1'b1;
    drive_in(1'b1, 32'h006281FF, 32'h6000); cyc();
    drive_in(1'b0, 32'h0, 32'h0);
    sample();
    chk("rst2_x5_cleared", 64'(bus.out_rs1_data), 64'd0);
    chk("rst2_x6_cleared", 64'(bus.out_rs2_data), 64'd0);
    chk("rst2_e_x5",       bus_e.out_rs1_data,    64'd0);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_regfile_pipe.md
Name: decode_regfile_pipe

Overview:
Parametrised successor to the single-cycle decode/register-file block. Combines a REG_COUNT x XLEN integer register file, a full RV32I immediate generator (I/S/B/U/J), and one registered output stage with a valid/ready handshake. Sits between fetch and execute. Handles writeback bypass, and refreshes operands while an instruction is stalled in the output slot.

Parameters:
XLEN, 32, datapath width; 32 or 64; immediates sign-extended to XLEN
REG_COUNT, 32, architectural registers; 32 (RV32I) or 16 (RV32E)
BYPASS, 1, 1 = same-cycle writeback forwarded into read data; 0 = plain read-before-write

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode can accept this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  PC of in_inst
wb_en  in  1  register write enable
wb_rd  in  5  write address
wb_data  in  XLEN  write data
out_valid  out  1  decoded instruction held in output slot
out_ready  in  1  execute consumes the slot
out_pc  out  XLEN  registered PC
out_inst  out  32  registered instruction
out_rs1_data  out  XLEN  rs1 operand
out_rs2_data  out  XLEN  rs2 operand
out_imm  out  XLEN  sign-extended immediate
out_rd  out  5  destination index
out_bad_reg  out  1  rs1, rs2 or rd index is >= REG_COUNT

Behaviour:
- Reset (rst=1 at posedge): all registers cleared to 0. out_valid=0. out_pc, out_inst, out_rs1_data, out_rs2_data, out_imm, out_rd and out_bad_reg are 0. Reset overrides any in-flight accept or writeback in the same cycle. in_ready=1 after reset.
- Handshake: in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. The slot loads on that posedge, so latency is 1 cycle.
  - If out_valid && out_ready && !(in_valid && in_ready), out_valid clears.
  - Simultaneous consume and accept: the slot is replaced and out_valid stays 1.
  - While out_valid && !out_ready, all out_* fields are stable, except the operand refresh below.
- Register file: 1 write port, 2 async read ports.
  - Write occurs at posedge when wb_en && wb_rd!=0 && wb_rd<REG_COUNT.
  - x0 always reads 0.
  - Indices >= REG_COUNT read as 0, writes to them are dropped, and out_bad_reg is set for the accepted instruction.
- Bypass (BYPASS=1): at accept, if wb_en && wb_rd==rsN && wb_rd!=0 && wb_rd<REG_COUNT, the captured operand is wb_data. With BYPASS=0 the old register value is captured.
- Operand refresh: while out_valid && !out_ready (or out_valid with no accept that cycle), a writeback whose wb_rd matches the held rs1/rs2 field (nonzero, in range) updates out_rs1_data/out_rs2_data at the same posedge. This applies for both BYPASS values.
- Immediate, selected by opcode in_inst[6:0], sign bit in_inst[31] extended to XLEN:
  - I, opcodes 0000011, 0010011, 1100111, 1110011: inst[31:20]
  - S, opcode 0100011: {inst[31:25], inst[11:7]}
  - B, opcode 1100011: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U, opcodes 0110111, 0010111: {inst[31:12], 12'b0}, sign-extended when XLEN=64
  - J, opcode 1101111: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - Any other opcode: 0
- Field indices: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7]. The operand and bad_reg logic ignores the opcode's format.
- in_inst is decoded only on accept; values presented without in_valid have no effect.

Test Plan:
- Reset then write x5=0xDEADBEEF; accept add x1,x5,x0 (0x000280B3) with out_ready=1 -> next cycle out_valid=1, out_rs1_data=0xDEADBEEF, out_rs2_data=0, out_rd=1, out_imm=0.
- BYPASS=1: accept an instruction reading x7 in the same cycle as wb x7=0x1234 -> out_rs1_data=0x1234. With BYPASS=0 the same stimulus -> out_rs1_data equals the old x7 value.
- Stall: hold out_ready=0 with the slot reading x3, then wb x3=0x55 -> out_rs1_data becomes 0x55 the next cycle; in_ready=0 and the new in_valid is not accepted; releasing out_ready accepts on that cycle.
- Immediates: inst 0xFE010CE3 (beq, offset -8) -> out_imm=0xFFFFFFF8. 0x800000EF (jal) -> 0xFFF00000. 0xFFFFF0B7 (lui) -> 0xFFFFF000 (XLEN=64: 0xFFFFFFFFFFFFF000). Opcode 0x7F -> 0.
- REG_COUNT=16: write x20 dropped and x0 write dropped (both read 0); instruction with rs2=x17 -> out_bad_reg=1, out_rs2_data=0.
- Assert rst with out_valid=1 and wb_en=1 -> next cycle out_valid=0, all out_* zero, all registers read 0.
